// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding
// and default sizing constants.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_NUM_REQ  = 4;
    localparam int unsigned ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from start upward with wrap-around
// and returns the first requesting, non-excluded index.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    input  logic [N-1:0]   excl,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0] cand_req;
    int unsigned  cand;

    assign cand_req = req & ~excl;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(start) + i) % N;
            if (!found && cand_req[IDW'(cand)]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with a bounded hold time, per-master lock against
// pre-emption, and registered one-hot grant outputs.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = ARB_NUM_REQ,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       preempt
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IDW-1:0]     last_id;
    logic [HCW-1:0]     hold_cnt;

    logic [IDW-1:0]     start_idx;
    logic [NUM_REQ-1:0] excl;
    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    logic               owner_req;
    logic               owner_lock;
    logic               hold_max;
    logic               do_grant;
    logic               go_idle;
    logic               is_preempt;

    assign start_idx  = (last_id == LAST_IDX) ? '0 : last_id + 1'b1;
    assign excl       = (state == ARB_OWNED) ? (NUM_REQ'(1) << gnt_id) : '0;
    assign owner_req  = req[gnt_id];
    assign owner_lock = lock[gnt_id];
    assign hold_max   = (hold_cnt == HCW'(MAX_HOLD));

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .start (start_idx),
        .excl  (excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The owner is excluded from the search, so a found winner always means
    // "some other master is waiting"; a release takes priority over pre-emption.
    assign is_preempt = (state == ARB_OWNED) && owner_req && hold_max && !owner_lock && pick_found;
    assign do_grant   = pick_found && ((state == ARB_IDLE) || !owner_req || (hold_max && !owner_lock));
    assign go_idle    = (state == ARB_OWNED) && !owner_req && !pick_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last_id   <= LAST_IDX;
        end else begin
            preempt <= is_preempt;
            if (do_grant) begin
                state     <= ARB_OWNED;
                gnt       <= NUM_REQ'(1) << pick_idx;
                gnt_valid <= 1'b1;
                gnt_id    <= pick_idx;
                last_id   <= pick_idx;
                hold_cnt  <= '0;
            end else if (go_idle) begin
                state     <= ARB_IDLE;
                gnt       <= '0;
                gnt_valid <= 1'b0;
                gnt_id    <= '0;
                hold_cnt  <= '0;
            end else if (state == ARB_OWNED && !hold_max) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_rr_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         preempt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    typedef struct {
        int owner;
        int last;
        int hold;
        bit pre;
    } mstate_t;

    mstate_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // First requesting master after 'last' in circular order, skipping 'excl'.
    function automatic int winner(logic [N-1:0] r, int last, int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    function automatic mstate_t mnext(mstate_t s, logic [N-1:0] r, logic [N-1:0] l);
        mstate_t n;
        int w;
        n = s;
        n.pre = 1'b0;
        if (s.owner < 0) begin
            w = winner(r, s.last, -1);
            if (w >= 0) begin n.owner = w; n.last = w; n.hold = 0; end
        end else if (!r[s.owner]) begin
            w = winner(r, s.last, s.owner);
            if (w >= 0) begin n.owner = w; n.last = w; n.hold = 0; end
            else begin n.owner = -1; n.hold = 0; end
        end else begin
            w = winner(r, s.last, s.owner);
            if (s.hold == MH && !l[s.owner] && w >= 0) begin
                n.owner = w; n.last = w; n.hold = 0; n.pre = 1'b1;
            end else if (s.hold < MH) begin
                n.hold = s.hold + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, last: N - 1, hold: 0, pre: 1'b0};
        else        m <= mnext(m, req, lock);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_gnt",   32'(gnt),       (m.owner < 0) ? 32'd0 : (32'd1 << m.owner));
            chk("m_valid", 32'(gnt_valid), (m.owner < 0) ? 32'd0 : 32'd1);
            chk("m_id",    32'(gnt_id),    (m.owner < 0) ? 32'd0 : 32'(m.owner));
            chk("m_pre",   32'(preempt),   32'(m.pre));
            chk("m_onehot", 32'($countones(gnt) <= 1), 32'd1);
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l);
        #1;
        req  = r;
        lock = l;
    endtask

    initial begin
        int cnt;
        int pulses;
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(gnt_valid), 0);
        chk("rst_id", 32'(gnt_id), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 0);

        // First grant after reset, lowest-after-last_id wins.
        drive(4'b0110, 4'b0000);
        @(negedge clk);
        chk("first_gnt", 32'(gnt), 32'b0010);
        chk("first_id", 32'(gnt_id), 1);
        chk("first_valid", 32'(gnt_valid), 1);

        // Release hands straight over to the next requester.
        drive(4'b0100, 4'b0000);
        @(negedge clk);
        chk("handoff_gnt", 32'(gnt), 32'b0100);

        drive(4'b1000, 4'b0000);
        @(negedge clk);
        chk("to3_gnt", 32'(gnt), 32'b1000);
        drive(4'b1001, 4'b0000);
        @(negedge clk);
        chk("hold3_gnt", 32'(gnt), 32'b1000);
        drive(4'b0001, 4'b0000);
        @(negedge clk);
        chk("wrap_gnt", 32'(gnt), 32'b0001);

        // Two contenders without lock alternate every MAX_HOLD+1 cycles.
        drive(4'b1001, 4'b0000);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (gnt == 4'b1000) begin cnt = i; break; end
        end
        chk("pre1_cycles", cnt, MH + 1);
        chk("pre1_pulse", 32'(preempt), 1);
        @(negedge clk);
        chk("pre1_pulse_end", 32'(preempt), 0);
        cnt = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clk);
            if (gnt == 4'b0001) begin cnt = i; break; end
        end
        chk("pre2_cycles", cnt, MH + 1);
        chk("pre2_pulse", 32'(preempt), 1);

        // Locked owner is never pre-empted.
        drive(4'b1001, 4'b0001);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (preempt) pulses++;
        end
        chk("lock_gnt", 32'(gnt), 32'b0001);
        chk("lock_pulses", pulses, 0);
        drive(4'b1000, 4'b0001);
        @(negedge clk);
        chk("lock_release_gnt", 32'(gnt), 32'b1000);
        chk("lock_release_pre", 32'(preempt), 0);

        // Sole requester keeps the grant past MAX_HOLD.
        drive(4'b0100, 4'b0000);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (preempt) pulses++;
        end
        chk("sole_gnt", 32'(gnt), 32'b0100);
        chk("sole_pulses", pulses, 0);

        // Asynchronous reset mid-grant.
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_valid", 32'(gnt_valid), 0);
        chk("async_id", 32'(gnt_id), 0);
        chk("async_pre", 32'(preempt), 0);
        req = 4'b1111;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);

        // Randomized traffic with sticky requests and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] r;
            logic [N-1:0] l;
            @(negedge clk);
            r = req;
            l = lock;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
                if ($urandom_range(9) == 0) l[b] = ~l[b];
            end
            drive(r, l);
            if ($urandom_range(499) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
